// File: rtl/l2_cache_if.sv
// Line-wide request bus between the L1 arbiter, the L2 cache and physical memory.
// Requests are levels held until a one-cycle *_resp pulse; read and write are never both meaningful at once.
interface l2_cache_if;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_addr;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_addr;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  l2_read, l2_write, l2_addr, l2_wdata, pmem_rdata, pmem_resp,
    output l2_rdata, l2_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output l2_read, l2_write, l2_addr, l2_wdata, pmem_rdata, pmem_resp,
    input  l2_rdata, l2_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 cache: whole 16-byte lines, dirty victim write-back then fill.
// Full-line write misses install directly without fetching the old line.
module l2_cache #(
  parameter int SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  l2_cache_if.slave   bus,
  output logic [2:0]  dbg_state
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 12 - IDX;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [11:0]       req_line_q, req_line_d;
  logic [127:0]      req_wdata_q, req_wdata_d;
  logic              req_write_q, req_write_d;
  logic              l2_resp_q, l2_resp_d;
  logic [127:0]      l2_rdata_q, l2_rdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;

  logic [127:0]      data_q [SETS];
  logic [TAGW-1:0]   tag_q  [SETS];
  logic              arr_we;
  logic [127:0]      arr_wdata;

  logic [IDX-1:0]    req_idx;
  logic [TAGW-1:0]   req_tag;
  logic              hit;

  assign req_idx = req_line_q[IDX-1:0];
  assign req_tag = req_line_q[11:IDX];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    req_line_d   = req_line_q;
    req_wdata_d  = req_wdata_q;
    req_write_d  = req_write_q;
    l2_resp_d    = 1'b0;
    l2_rdata_d   = l2_rdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    arr_we       = 1'b0;
    arr_wdata    = req_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.l2_read || bus.l2_write) begin
          req_line_d  = bus.l2_addr[15:4];
          req_wdata_d = bus.l2_wdata;
          req_write_d = bus.l2_write;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          l2_resp_d = 1'b1;
          if (req_write_q) begin
            arr_we           = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end else begin
            l2_rdata_d = data_q[req_idx];
          end
          state_d = S_DONE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          pmem_write_d = 1'b1;
          state_d      = S_WB;
        end else if (req_write_q) begin
          // Whole-line write: nothing of the old line survives, so skip the fill.
          arr_we           = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b1;
          l2_resp_d        = 1'b1;
          state_d          = S_DONE;
        end else begin
          pmem_read_d = 1'b1;
          state_d     = S_FILL;
        end
      end
      S_WB: begin
        if (bus.pmem_resp) begin
          pmem_write_d     = 1'b0;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_LOOKUP;
        end
      end
      S_FILL: begin
        if (bus.pmem_resp) begin
          pmem_read_d      = 1'b0;
          arr_we           = 1'b1;
          arr_wdata        = bus.pmem_rdata;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_LOOKUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_line_q   <= '0;
      req_wdata_q  <= '0;
      req_write_q  <= 1'b0;
      l2_resp_q    <= 1'b0;
      l2_rdata_q   <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_line_q   <= req_line_d;
      req_wdata_q  <= req_wdata_d;
      req_write_q  <= req_write_d;
      l2_resp_q    <= l2_resp_d;
      l2_rdata_q   <= l2_rdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Line storage is not reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_q[req_idx] <= arr_wdata;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign bus.l2_resp    = l2_resp_q;
  assign bus.l2_rdata   = l2_rdata_q;
  assign bus.pmem_read  = pmem_read_q;
  assign bus.pmem_write = pmem_write_q;
  assign bus.pmem_addr  = (state_q == S_WB) ? {tag_q[req_idx], req_idx, 4'b0000}
                                            : {req_line_q, 4'b0000};
  assign bus.pmem_wdata = data_q[req_idx];
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_l2_cache.sv
// Randomized bench for l2_cache: behavioural memory responder plus a line-level cache model
// that predicts read data, write-back victims and fills for every request.
module tb_l2_cache;
  localparam int SETS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  l2_cache_if bus ();

  l2_cache #(.SETS(SETS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Physical memory, lazily seeded with an address-derived pattern.
  logic [127:0] mem [int];

  function automatic logic [127:0] init_line(input int line);
    logic [31:0] l;
    l = line;
    return {32'hA5A50000 ^ l, ~l, l * 32'h9E3779B1, 32'hC0FFEE00 ^ l};
  endfunction

  function automatic logic [127:0] mem_get(input int line);
    if (!mem.exists(line)) mem[line] = init_line(line);
    return mem[line];
  endfunction

  // Memory responder: pulses pmem_resp a few cycles after a strobe is seen.
  int fix_dly  = -1;
  bit stall    = 1'b0;
  int wait_cnt = -1;

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (reset || stall || !(bus.pmem_read || bus.pmem_write)) begin
        wait_cnt = -1;
      end else begin
        if (wait_cnt < 0) wait_cnt = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 4));
        if (wait_cnt == 0) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_read) bus.pmem_rdata = mem_get(int'(bus.pmem_addr >> 4));
          else               mem[int'(bus.pmem_addr >> 4)] = bus.pmem_wdata;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  int           cyc = 0, rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;
  int           rd_cyc = 0, wr_cyc = 0, presp_cyc = 0, lresp_cyc = 0;
  logic [15:0]  last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.pmem_read && bus.pmem_write) both_cnt++;
      if (bus.pmem_resp && bus.pmem_read && !reset) begin
        rd_cnt++; rd_cyc = cyc; presp_cyc = cyc; last_rd_addr = bus.pmem_addr;
      end
      if (bus.pmem_resp && bus.pmem_write && !reset) begin
        wr_cnt++; wr_cyc = cyc; presp_cyc = cyc;
        last_wr_addr = bus.pmem_addr; last_wr_data = bus.pmem_wdata;
      end
      if (bus.l2_resp) begin
        resp_cnt++; lresp_cyc = cyc;
      end
    end
  end

  // Reference cache contents, one entry per set.
  logic         rv   [SETS];
  logic         rdy  [SETS];
  int           rtag [SETS];
  logic [127:0] rdat [SETS];

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) begin
      rv[i] = 1'b0; rdy[i] = 1'b0; rtag[i] = 0; rdat[i] = '0;
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [127:0] wd, input bit chk_lat);
    int           line, idx, tg, lat, r0, w0, p0;
    bit           hit, exp_wb, exp_fill;
    logic [15:0]  vaddr;
    logic [127:0] vdata, exp_rd, got;
    line     = int'(addr >> 4);
    idx      = line % SETS;
    tg       = line / SETS;
    hit      = rv[idx] && (rtag[idx] == tg);
    exp_wb   = !hit && rv[idx] && rdy[idx];
    exp_fill = !hit && !wr;
    vaddr    = 16'((rtag[idx] * SETS + idx) * 16);
    vdata    = rdat[idx];
    exp_rd   = hit ? rdat[idx] : mem_get(line);
    r0 = resp_cnt; w0 = wr_cnt; p0 = rd_cnt;
    lat = 0;
    bus.l2_read  = rd;
    bus.l2_write = wr;
    bus.l2_addr  = {addr[15:4], 4'($urandom_range(0, 15))};
    bus.l2_wdata = wd;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.l2_resp) break;
      if (lat >= 300) begin
        check("resp_timeout", 128'(lat), 128'(0));
        break;
      end
    end
    got = bus.l2_rdata;
    // Hold the request across the dead cycle; it must not start a second transaction.
    @(posedge clk);
    #1;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    check("resp_once", 128'(resp_cnt - r0), 128'(1));
    check("pmem_wr_count", 128'(wr_cnt - w0), 128'(exp_wb));
    check("pmem_rd_count", 128'(rd_cnt - p0), 128'(exp_fill));
    if (exp_wb) begin
      check("wb_addr", 128'(last_wr_addr), 128'(vaddr));
      check("wb_data", last_wr_data, vdata);
    end
    if (exp_fill) begin
      check("fill_addr", 128'(last_rd_addr), 128'({addr[15:4], 4'b0000}));
      check("fill_to_resp", 128'(lresp_cyc - presp_cyc), 128'(2));
    end
    if (exp_wb && exp_fill) check("wb_before_fill", 128'(wr_cyc < rd_cyc), 128'(1));
    if (!wr) check("rdata", got, exp_rd);
    if (chk_lat && (hit || (wr && !exp_wb))) check("latency", 128'(lat), 128'(2));
    if (!hit) begin
      rv[idx] = 1'b1; rtag[idx] = tg; rdy[idx] = 1'b0; rdat[idx] = mem_get(line);
    end
    if (wr) begin
      rdat[idx] = wd; rdy[idx] = 1'b1;
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] lb, lc, ld, le;
    int           k;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    bus.l2_addr  = '0;
    bus.l2_wdata = '0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 128'(dbg_state), 128'(0));
    check("rst_l2_resp", 128'(bus.l2_resp), 128'(0));
    check("rst_pmem_read", 128'(bus.pmem_read), 128'(0));
    check("rst_pmem_write", 128'(bus.pmem_write), 128'(0));
    check("rst_pmem_addr", 128'(bus.pmem_addr), 128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold read miss with a fixed 3-cycle memory, then a hit.
    fix_dly = 3;
    do_req(1'b1, 1'b0, 16'h0040, '0, 1'b1);
    fix_dly = -1;
    do_req(1'b1, 1'b0, 16'h0040, '0, 1'b1);

    // Write hit makes the line dirty; an aliasing read evicts it.
    lb = rand_line();
    do_req(1'b0, 1'b1, 16'h0040, lb, 1'b1);
    do_req(1'b1, 1'b0, 16'h0440, '0, 1'b1);

    // Clean write miss installs without traffic; dirty write miss writes back only.
    lc = rand_line();
    do_req(1'b0, 1'b1, 16'h1230, lc, 1'b1);
    do_req(1'b1, 1'b0, 16'h1230, '0, 1'b1);
    ld = rand_line();
    do_req(1'b0, 1'b1, 16'h5230, ld, 1'b1);

    // Reset while a fill is outstanding.
    stall        = 1'b1;
    bus.l2_read  = 1'b1;
    bus.l2_addr  = 16'h0840;
    k = 0;
    while (!bus.pmem_read && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("fill_started", 128'(bus.pmem_read), 128'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_pmem_read", 128'(bus.pmem_read), 128'(0));
    check("rst_mid_state", 128'(dbg_state), 128'(0));
    bus.l2_read = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    // The dirty line written before reset is gone; memory's copy comes back.
    do_req(1'b1, 1'b0, 16'h5230, '0, 1'b1);

    // Read and write together behave as a write.
    le = rand_line();
    do_req(1'b1, 1'b1, 16'h0080, le, 1'b1);
    do_req(1'b1, 1'b0, 16'h0080, '0, 1'b1);

    // Random traffic over a small tag pool so sets alias often, including index 0 and SETS-1.
    for (int i = 0; i < 200; i++) begin
      int          sel;
      logic [15:0] a;
      a   = 16'(($urandom_range(0, 3) * SETS + $urandom_range(0, SETS - 1)) * 16);
      sel = $urandom_range(0, 9);
      if (sel < 5)      do_req(1'b1, 1'b0, a, '0, 1'b1);
      else if (sel < 9) do_req(1'b0, 1'b1, a, rand_line(), 1'b1);
      else              do_req(1'b1, 1'b1, a, rand_line(), 1'b1);
    end

    check("pmem_strobe_overlap", 128'(both_cnt), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_cache.md
# l2_cache

Unified, direct-mapped, write-back second-level cache between the L1 arbiter's line-wide request port and physical memory. It acts as the responder for the arbiter's 128-bit line read/write protocol and as the initiator toward physical memory on the same protocol. Every request is a whole 16-byte line. Misses are handled with write-back of a dirty victim followed by a fill; full-line write misses skip the fill.

## Interface
- SETS, 8: number of lines; power of two, at least 2. IDX = log2(SETS).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- l2_read  in  1  line read request from the arbiter; held until l2_resp.
- l2_write  in  1  line write request from the arbiter; held until l2_resp.
- l2_addr  in  16  request byte address; bits [3:0] ignored.
- l2_wdata  in  128  write line; stable while l2_write is high.
- l2_rdata  out  128  read line; valid only while l2_resp is high.
- l2_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line read to physical memory; held until pmem_resp.
- pmem_write  out  1  line write to physical memory; held until pmem_resp.
- pmem_addr  out  16  physical line address, bits [3:0] always 0.
- pmem_wdata  out  128  victim line during write-back.
- pmem_rdata  in  128  fill line; valid in the cycle pmem_resp is high.
- pmem_resp  in  1  one-cycle completion from physical memory.

## Operation
- Address split: offset [3:0], index [3+IDX:4], tag [15:4+IDX]. For SETS=8 the index is [6:4] and the tag is [15:7].
- Per set: data line (128 b), tag, valid bit, dirty bit.
- Request register: IDLE latches l2_addr, l2_wdata and op (write if l2_write, else read) on the first edge where l2_read or l2_write is high.
- Read and write asserted together is illegal; write takes priority.
- State machine: IDLE, LOOKUP, WB, FILL, DONE.
- IDLE: no outputs asserted. If a request is present, latch it and go to LOOKUP.
- LOOKUP, hit (valid and tag match):
  - Read: assert l2_resp, drive l2_rdata from the set.
  - Write: assert l2_resp, write the line, set dirty.
  - Either case then goes to DONE.
- LOOKUP, miss with a dirty victim: go to WB.
- LOOKUP, clean miss:
  - Read: go to FILL.
  - Write: install l2_wdata with valid=1, dirty=1, tag=request tag; assert l2_resp; go to DONE.
- WB:
  - Assert pmem_write with pmem_addr = {victim tag, index, 4'b0} and pmem_wdata = victim line.
  - On pmem_resp, clear dirty and go to LOOKUP. A write then installs; a read proceeds to FILL.
- FILL:
  - Assert pmem_read with pmem_addr = {request tag, index, 4'b0}.
  - On pmem_resp, store pmem_rdata with valid=1, dirty=0, tag=request tag, then go to LOOKUP, which now hits.
- DONE: one dead cycle so the requester can drop its request; then IDLE. Requests are not sampled in DONE.
- pmem_read and pmem_write are never high together. pmem_addr reflects the request register outside WB.

## Timing
- Reset values (asynchronous):
  - State IDLE; all valid and dirty bits 0; request register 0.
  - l2_resp=0, pmem_read=0, pmem_write=0, pmem_addr=0.
  - Data and tag arrays are not reset.
- Hit: request first seen at edge 0; l2_resp high in the cycle after edge 1 (1-cycle latency from latch). Next request can be latched at edge 3.
- Clean read miss: pmem_read rises one cycle after LOOKUP and stays high through the pmem_resp cycle. l2_resp follows 2 cycles after pmem_resp (FILL→LOOKUP→resp).
- Dirty read miss: WB then FILL back-to-back, with one LOOKUP cycle between them.
- pmem_resp outside WB/FILL is ignored. pmem_resp arriving in the same cycle a request is first asserted has no effect.
- Reset mid-operation aborts the transaction: pmem strobes drop immediately, and unwritten dirty data is discarded.
- Index wrap-around: addresses differing only in tag alias to the same set; index 0 and index SETS-1 behave identically.

## Test plan
- After reset, read 0x0040 with pmem returning line A after 3 cycles.
  - Required: one pmem_read at 0x0040, l2_rdata=A with l2_resp.
  - Re-read 0x0040: l2_resp one cycle after latch with no pmem activity.
- Write line B to 0x0040 (hit), then read 0x0440 (same index 4, different tag).
  - Required: pmem_write to 0x0040 with B, then pmem_read 0x0440, then l2_resp.
- Write miss to clean set 0x1230 with line C.
  - Required: no pmem traffic, l2_resp two cycles after request.
  - Re-read 0x1230 returns C.
- Write miss to a dirty set.
  - Required: exactly one pmem_write of the victim, no pmem_read; new line dirty.
- Assert reset while in FILL with pmem_read high.
  - Required: pmem_read=0 immediately, state IDLE.
  - Previous hit address now misses.
- l2_read and l2_write high together at 0x0080.
  - Required: treated as a write; l2_resp exactly once; DONE ignores the still-high request for one cycle.
